// File: rtl/vga_pkg.sv
// Shared types and timing helpers for the raster timing generator.
// Default constants describe standard 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    int act;
    int front;
    int sync;
    int back;
  } timing_t;

  typedef struct packed {
    int start;
    int total;
  } derived_t;

  // Blanking is placed at negative coordinates so active video starts at 0.
  function automatic derived_t derive(timing_t t);
    derived_t d;
    d.start = -(t.front + t.sync + t.back);
    d.total = t.act - d.start;
    return d;
  endfunction

  localparam timing_t VGA640_H = '{act: 640, front: 16, sync: 96, back: 48};
  localparam timing_t VGA640_V = '{act: 480, front: 10, sync: 2,  back: 33};

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a per-bit asynchronous reset value.
module vga_delay_line #(
  parameter int            W       = 1,
  parameter int            DEPTH   = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= {DEPTH{RST_VAL}};
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: signed lookahead coordinates, delayed
// sync/de, frame-aligned start/stop control and a completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT   = VGA640_H.act,
  parameter int H_FRONT = VGA640_H.front,
  parameter int H_SYNC  = VGA640_H.sync,
  parameter int H_BACK  = VGA640_H.back,
  parameter int V_ACT   = VGA640_V.act,
  parameter int V_FRONT = VGA640_V.front,
  parameter int V_SYNC  = VGA640_V.sync,
  parameter int V_BACK  = VGA640_V.back,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int PIPE    = 1,
  parameter int CW      = 16
) (
  input  logic                 clk_25M,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  output logic                 o_hs,
  output logic                 o_vs,
  output logic                 o_blank_n,
  output logic                 o_sync_n,
  output logic                 o_de,
  output logic                 o_line,
  output logic                 o_frame,
  output logic signed [CW-1:0] o_sx,
  output logic signed [CW-1:0] o_sy,
  output logic [15:0]          o_frame_cnt,
  output logic                 o_running
);

  typedef logic signed [CW-1:0] crd_t;

  localparam derived_t HD = derive('{act: H_ACT, front: H_FRONT, sync: H_SYNC, back: H_BACK});
  localparam derived_t VD = derive('{act: V_ACT, front: V_FRONT, sync: V_SYNC, back: V_BACK});
  localparam int CMAX = 2**(CW-1) - 1;

  if (HD.total > CMAX || VD.total > CMAX) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for the frame totals");
  end
  if (PIPE < 1 || PIPE > 8) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be within 1..8");
  end

  localparam crd_t H_START = crd_t'(HD.start);
  localparam crd_t V_START = crd_t'(VD.start);
  localparam crd_t H_LAST  = crd_t'(H_ACT - 1);
  localparam crd_t V_LAST  = crd_t'(V_ACT - 1);
  localparam crd_t HS_BEG  = crd_t'(HD.start + H_FRONT);
  localparam crd_t HS_END  = crd_t'(HD.start + H_FRONT + H_SYNC);
  localparam crd_t VS_BEG  = crd_t'(VD.start + V_FRONT);
  localparam crd_t VS_END  = crd_t'(VD.start + V_FRONT + V_SYNC);
  localparam crd_t C_ONE   = crd_t'(1);
  localparam logic HP      = 1'(H_POL);
  localparam logic VP      = 1'(V_POL);

  state_t      state_q;
  crd_t        sx_q, sy_q;
  logic [15:0] fcnt_q;

  logic run, eol, eof;
  assign run = (state_q != IDLE);
  assign eol = (sx_q == H_LAST);
  assign eof = eol && (sy_q == V_LAST);

  // Start wins over stop in IDLE/DRAIN, stop wins in RUN.
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sx_q    <= H_START;
      sy_q    <= V_START;
      fcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE:    if (i_start) state_q <= RUN;
        RUN:     if (i_stop)  state_q <= DRAIN;
        DRAIN:   if (i_start) state_q <= RUN;
                 else if (eof) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (run) begin
        if (eol) begin
          sx_q <= H_START;
          sy_q <= eof ? V_START : sy_q + C_ONE;
        end else begin
          sx_q <= sx_q + C_ONE;
        end
        if (eof) fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

  // Raw flags are gated by run so an IDLE generator emits inactive levels,
  // which also flushes the delay line after a frame-aligned stop.
  logic hs_act, vs_act, de_raw, line_raw, hs_lvl, vs_lvl;
  assign hs_act   = run && (sx_q >= HS_BEG) && (sx_q < HS_END);
  assign vs_act   = run && (sy_q >= VS_BEG) && (sy_q < VS_END);
  assign de_raw   = run && !sx_q[CW-1] && !sy_q[CW-1];
  assign line_raw = run && (sx_q == H_START) && !sy_q[CW-1];
  assign hs_lvl   = hs_act ? HP : ~HP;
  assign vs_lvl   = vs_act ? VP : ~VP;

  vga_delay_line #(
    .W      (4),
    .DEPTH  (PIPE),
    .RST_VAL({~HP, ~VP, 2'b00})
  ) u_dly (
    .clk  (clk_25M),
    .rst_n(rst_n),
    .d_i  ({hs_lvl, vs_lvl, de_raw, line_raw}),
    .q_o  ({o_hs, o_vs, o_de, o_line})
  );

  assign o_blank_n   = o_de;
  assign o_sync_n    = 1'b0;
  assign o_frame     = run && (sx_q == H_START) && (sy_q == V_START);
  assign o_sx        = sx_q;
  assign o_sy        = sy_q;
  assign o_frame_cnt = fcnt_q;
  assign o_running   = run;

endmodule
